// File: rtl/audio_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_mon_pkg
// Description : Shared types and helpers for the audio tone monitor.
//               Holds the controller state encoding, the NUM_CYC limit and
//               the log2 helper used to turn the summed period into the
//               per-cycle average.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_mon_pkg;

   // Largest number of averaged cycles the per-channel crossing counter holds.
   localparam int MAX_NUM_CYC = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      MEASURE = 3'd2,
      CHECK   = 3'd3,
      DONE    = 3'd4
   } mon_state_t;

   // log2 of a power-of-two cycle count in 1..MAX_NUM_CYC.
   function automatic int clog2_cyc(input int n);
      int r;
      r = 0;
      for (int i = 0; (1 << i) <= MAX_NUM_CYC; i++) begin
         if ((1 << i) == n) r = i;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tone_chan_meas.sv
`default_nettype none
// ============================================================================
// Module      : tone_chan_meas
// Description : One channel of the tone monitor. Hysteresis zero-crossing
//               detector, period sample counter and max/min tracker.
//   clk, rst        : clock, async active-high reset
//   clear           : accepted start; re-initialises all channel state
//   meas_en         : controller is in MEASURE
//   smpl_vld        : sample strobe
//   sample          : signed sample for this channel
//   complete        : NUM_CYC full cycles seen after the first crossing
//   total           : samples spanned by those NUM_CYC cycles
//   smpl_max/min    : extreme samples seen during MEASURE
// Revision    : 1.0 - initial release
// ============================================================================
module tone_chan_meas
   import audio_mon_pkg::*;
#(
   parameter int SMPL_W  = 16,
   parameter int CNT_W   = 16,
   parameter int NUM_CYC = 4,
   parameter int HYST    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     meas_en,
   input  logic                     smpl_vld,
   input  logic signed [SMPL_W-1:0] sample,
   output logic                     complete,
   output logic        [CNT_W-1:0]  total,
   output logic signed [SMPL_W-1:0] smpl_max,
   output logic signed [SMPL_W-1:0] smpl_min
);

   localparam int XCNT_W = $clog2(MAX_NUM_CYC + 1);

   localparam logic signed [SMPL_W-1:0] c_hyst_pos  = SMPL_W'(HYST);
   localparam logic signed [SMPL_W-1:0] c_hyst_neg  = SMPL_W'(-HYST);
   localparam logic signed [SMPL_W-1:0] c_most_pos  = {1'b0, {(SMPL_W-1){1'b1}}};
   localparam logic signed [SMPL_W-1:0] c_most_neg  = {1'b1, {(SMPL_W-1){1'b0}}};
   localparam logic        [XCNT_W-1:0] c_last_xing = XCNT_W'(NUM_CYC - 1);

   logic              r_armed;
   logic              r_started;
   logic [CNT_W-1:0]  r_cnt;
   logic [XCNT_W-1:0] r_xcnt;

   logic              w_strobe;
   logic              w_rise;
   logic [CNT_W-1:0]  w_cnt_inc;

   assign w_strobe  = meas_en & smpl_vld;
   // A rising crossing needs a prior excursion below -HYST, so noise inside
   // the +/-HYST band can never produce one.
   assign w_rise    = r_armed && (sample >= c_hyst_pos);
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed   <= 1'b0;
         r_started <= 1'b0;
         r_cnt     <= '0;
         r_xcnt    <= '0;
         complete  <= 1'b0;
         total     <= '0;
         smpl_max  <= '0;
         smpl_min  <= '0;
      end else if (clear) begin
         r_armed   <= 1'b0;
         r_started <= 1'b0;
         r_cnt     <= '0;
         r_xcnt    <= '0;
         complete  <= 1'b0;
         total     <= '0;
         smpl_max  <= c_most_neg;
         smpl_min  <= c_most_pos;
      end else if (w_strobe) begin
         if (sample > smpl_max) smpl_max <= sample;
         if (sample < smpl_min) smpl_min <= sample;
         if (!complete) begin
            if (w_rise)
               r_armed <= 1'b0;
            else if (sample <= c_hyst_neg)
               r_armed <= 1'b1;

            if (!r_started) begin
               // First crossing only establishes the phase reference.
               if (w_rise) begin
                  r_started <= 1'b1;
                  r_cnt     <= '0;
               end
            end else begin
               r_cnt <= w_cnt_inc;
               if (w_rise) begin
                  r_xcnt <= r_xcnt + 1'b1;
                  if (r_xcnt == c_last_xing) begin
                     total    <= w_cnt_inc;
                     complete <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/audio_tone_monitor.sv
`default_nettype none
// ============================================================================
// Module      : audio_tone_monitor
// Description : Per-channel tone analyser. After start it discards
//               SETTLE_SMPLS sample frames, then measures average period and
//               amplitude over NUM_CYC cycles per channel and compares them
//               with the expected values and tolerances.
//   clk, rst                : clock, async active-high reset
//   start                   : begin a measurement (accepted in IDLE/DONE)
//   smpl_vld, smpl_data     : sample frame strobe and NUM_CH signed samples
//   exp_period, period_tol  : expected period and allowed error (samples)
//   exp_amp, amp_tol        : expected amplitude and allowed error (LSBs)
//   busy                    : SETTLE, MEASURE or CHECK
//   done                    : verdict valid, held until next start
//   period, amp             : per-channel measured results
//   ch_pass, all_pass       : per-channel and overall verdicts
//   timeout                 : measurement ended by the sample budget
// Revision    : 1.0 - initial release
// ============================================================================
module audio_tone_monitor
   import audio_mon_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int SMPL_W        = 16,
   parameter int CNT_W         = 16,
   parameter int NUM_CYC       = 4,
   parameter int SETTLE_SMPLS  = 2045,
   parameter int HYST          = 16,
   parameter int TIMEOUT_SMPLS = 8192
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       smpl_vld,
   input  logic [NUM_CH*SMPL_W-1:0]   smpl_data,
   input  logic [CNT_W-1:0]           exp_period,
   input  logic [CNT_W-1:0]           period_tol,
   input  logic [SMPL_W-1:0]          exp_amp,
   input  logic [SMPL_W-1:0]          amp_tol,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_CH*CNT_W-1:0]    period,
   output logic [NUM_CH*SMPL_W-1:0]   amp,
   output logic [NUM_CH-1:0]          ch_pass,
   output logic                       timeout,
   output logic                       all_pass
);

   localparam int               c_log2_cyc     = clog2_cyc(NUM_CYC);
   localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_SMPLS - 1);
   localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_SMPLS - 1);

   mon_state_t       r_state;
   logic [CNT_W-1:0] r_settle_cnt;
   logic [CNT_W-1:0] r_meas_cnt;

   logic                               w_accept;
   logic                               w_meas_en;
   logic [NUM_CH-1:0]                  w_complete;
   logic [NUM_CH-1:0]                  w_pass;
   logic [NUM_CH-1:0][CNT_W-1:0]       w_period;
   logic [NUM_CH-1:0][SMPL_W-1:0]      w_amp;

   assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_meas_en = (r_state == MEASURE);
   assign busy      = (r_state == SETTLE) || (r_state == MEASURE) || (r_state == CHECK);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic signed [SMPL_W-1:0] w_max;
      logic signed [SMPL_W-1:0] w_min;
      logic        [CNT_W-1:0]  w_total;
      logic signed [SMPL_W:0]   w_span;
      logic        [CNT_W:0]    w_pdiff;
      logic        [CNT_W:0]    w_pmag;
      logic        [SMPL_W:0]   w_adiff;
      logic        [SMPL_W:0]   w_amag;

      tone_chan_meas #(
         .SMPL_W  (SMPL_W),
         .CNT_W   (CNT_W),
         .NUM_CYC (NUM_CYC),
         .HYST    (HYST)
      ) u_meas (
         .clk      (clk),
         .rst      (rst),
         .clear    (w_accept),
         .meas_en  (w_meas_en),
         .smpl_vld (smpl_vld),
         .sample   (smpl_data[i*SMPL_W +: SMPL_W]),
         .complete (w_complete[i]),
         .total    (w_total),
         .smpl_max (w_max),
         .smpl_min (w_min)
      );

      // Span is formed one bit wider so full-scale max-min cannot wrap.
      assign w_span      = {w_max[SMPL_W-1], w_max} - {w_min[SMPL_W-1], w_min};
      assign w_amp[i]    = SMPL_W'(w_span >>> 1);
      assign w_period[i] = w_complete[i] ? (w_total >> c_log2_cyc) : '0;

      // Errors are taken with a guard bit and folded to a magnitude.
      assign w_pdiff = {1'b0, w_period[i]} - {1'b0, exp_period};
      assign w_pmag  = w_pdiff[CNT_W] ? (~w_pdiff + 1'b1) : w_pdiff;
      assign w_adiff = {1'b0, w_amp[i]} - {1'b0, exp_amp};
      assign w_amag  = w_adiff[SMPL_W] ? (~w_adiff + 1'b1) : w_adiff;

      assign w_pass[i] = w_complete[i]
                         && (w_pmag <= {1'b0, period_tol})
                         && (w_amag <= {1'b0, amp_tol});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_meas_cnt   <= '0;
         done         <= 1'b0;
         period       <= '0;
         amp          <= '0;
         ch_pass      <= '0;
         timeout      <= 1'b0;
         all_pass     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_settle_cnt <= '0;
                  r_meas_cnt   <= '0;
                  done         <= 1'b0;
                  period       <= '0;
                  amp          <= '0;
                  ch_pass      <= '0;
                  timeout      <= 1'b0;
                  all_pass     <= 1'b0;
                  r_state      <= (SETTLE_SMPLS == 0) ? MEASURE : SETTLE;
               end
            end
            SETTLE: begin
               if (smpl_vld) begin
                  if (r_settle_cnt == c_settle_last)
                     r_state <= MEASURE;
                  else
                     r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            MEASURE: begin
               // The budget check comes first so a strobe that both times
               // out and completes the last channel still flags timeout.
               if (smpl_vld && (r_meas_cnt == c_timeout_last)) begin
                  timeout <= 1'b1;
                  r_state <= CHECK;
               end else if (&w_complete) begin
                  r_state <= CHECK;
               end else if (smpl_vld) begin
                  r_meas_cnt <= r_meas_cnt + 1'b1;
               end
            end
            CHECK: begin
               period   <= w_period;
               amp      <= w_amp;
               ch_pass  <= w_pass;
               all_pass <= (&w_pass) && !timeout;
               done     <= 1'b1;
               r_state  <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
